// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program image into instruction memory, then holds the
// CPU in reset for RESET_HOLD cycles before releasing it.
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RESET_HOLD = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int unsigned HOLD_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HOLD  = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [HOLD_W-1:0]     hold_cnt;
    logic                  handshake;

    // Ready is a pure decode of the registered state, so it never depends on s_valid.
    assign s_ready   = (state == LOAD);
    assign handshake = s_valid & s_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_reset_n  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            word_count   <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    if (handshake) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= s_data;
                        ptr        <= ptr + 1'b1;
                        word_count <= word_count + 1'b1;
                        // A last word at the top address is a legal full image.
                        if (s_last) begin
                            state <= HOLD;
                        end else if (ptr == LAST_ADDR) begin
                            state        <= ERROR;
                            overflow_err <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
                        state       <= RUN;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        cpu_reset_n <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN, ERROR: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
